// File: rtl/read_cache_pkg.sv
// Shared command codes and controller states for the read cache, the core model
// and the memory model.
package read_cache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [3:0] {
    CMD_IDLE  = 4'h0,
    CMD_READ  = 4'h1,
    CMD_WRITE = 4'h2
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/read_cache_array.sv
// Direct-mapped tag/valid/data storage: one combinational read port, one write
// port, and a bulk valid clear that wins over a same-cycle write.
module read_cache_array
  import read_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [WORD_W-1:0] wr_data
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [WORD_W-1:0] words [LINES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

endmodule

// File: rtl/read_cache.sv
// Direct-mapped, one-word-per-line read cache with write-through, no-allocate
// writes and deferred flush while a memory transaction is in flight.
module read_cache
  import read_cache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  cCommand,
  input  logic [31:0] cAddress,
  input  logic [31:0] cData,
  output logic        hReady,
  output logic        hSignal,
  output logic [31:0] hData,
  input  logic        flush,
  output logic [3:0]  mCommand,
  output logic [31:0] mAddress,
  output logic [31:0] mData,
  input  logic        mReady,
  input  logic        mSignal,
  input  logic [31:0] mData_r
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  state_e            state, state_nxt;
  logic              flush_pend;
  logic [31:0]       req_addr, req_data, resp_data;
  logic              rd_valid, hit, is_read, is_write, accept, clear_all;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [31:0]       wr_data;
  logic              unused_byte_bits;

  assign unused_byte_bits = ^cAddress[1:0];
  assign is_read  = (cCommand == CMD_READ);
  assign is_write = (cCommand == CMD_WRITE);
  assign hit      = rd_valid && (rd_tag == cAddress[31 -: TAG_W]);

  read_cache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear_all),
    .rd_idx   (cAddress[2 +: IDX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    state_nxt = state;
    hReady    = 1'b0;
    hSignal   = 1'b0;
    mCommand  = CMD_IDLE;
    accept    = 1'b0;
    clear_all = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = cAddress[2 +: IDX_W];
    wr_tag    = cAddress[31 -: TAG_W];
    wr_data   = cData;
    case (state)
      ST_IDLE: begin
        hReady    = !flush;
        clear_all = flush;
        if (!flush && (is_read || is_write)) begin
          accept = 1'b1;
          if (is_write) begin
            state_nxt = ST_WR_REQ;
            wr_en     = hit;  // write-through updates a resident line only
          end else begin
            state_nxt = hit ? ST_RESP : ST_MISS_REQ;
          end
        end
      end
      ST_MISS_REQ: begin
        mCommand = CMD_READ;
        if (mReady) state_nxt = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (mSignal) begin
          wr_en     = 1'b1;
          wr_idx    = req_addr[2 +: IDX_W];
          wr_tag    = req_addr[31 -: TAG_W];
          wr_data   = mData_r;
          state_nxt = ST_RESP;
        end
      end
      ST_WR_REQ: begin
        mCommand = CMD_WRITE;
        if (mReady) state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (mSignal) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        hSignal   = 1'b1;
        clear_all = flush_pend || flush;  // deferred flush lands after the fill
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      resp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_addr  <= word_align(cAddress);
        req_data  <= cData;
        resp_data <= is_read ? rd_data : '0;
      end
      if (state == ST_MISS_WAIT && mSignal) resp_data <= mData_r;
      if (state == ST_RESP) flush_pend <= 1'b0;
      else if (state != ST_IDLE && flush) flush_pend <= 1'b1;
    end
  end

  assign hData    = (state == ST_RESP) ? resp_data : '0;
  assign mAddress = req_addr;
  assign mData    = req_data;

endmodule

// File: tb/tb_read_cache.sv
// Directed bench for read_cache: a line-level cache model plus a bench-owned
// memory, with a per-cycle compare process on the core and memory outputs.
module tb_read_cache;
  import read_cache_pkg::*;

  localparam int LINES = 16;
  localparam int IDX_W = $clog2(LINES);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cCommand = 4'h0;
  logic [31:0] cAddress = '0, cData = '0;
  logic        hReady, hSignal;
  logic [31:0] hData;
  logic        flush = 1'b0;
  logic [3:0]  mCommand;
  logic [31:0] mAddress, mData;
  logic        mReady = 1'b0, mSignal = 1'b0;
  logic [31:0] mData_r = '0;

  read_cache #(.LINES(LINES)) dut (
    .clock(clock), .reset(reset), .cCommand(cCommand), .cAddress(cAddress),
    .cData(cData), .hReady(hReady), .hSignal(hSignal), .hData(hData),
    .flush(flush), .mCommand(mCommand), .mAddress(mAddress), .mData(mData),
    .mReady(mReady), .mSignal(mSignal), .mData_r(mData_r)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Cache model: what each line holds according to the hit/fill/flush rules.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];

  logic [3:0]  cur_cmd = 4'h0;
  logic [31:0] cur_addr = '0, cur_data = '0;
  bit          cur_expect_mem = 1'b0;
  int          n_req = 0;
  int          stall_cfg = 0;
  int          lat_cfg = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Memory responder: mReady after stall_cfg cycles, mSignal lat_cfg+1 cycles after handshake.
  initial begin
    logic [3:0]  last_cmd;
    logic [31:0] last_addr, last_data, resp_val;
    int stall_cnt, sig_cnt;
    bit sig_active;
    last_cmd = 4'h0; last_addr = '0; last_data = '0; resp_val = '0;
    stall_cnt = 0; sig_cnt = 0; sig_active = 1'b0;
    forever begin
      @(negedge clock);
      mSignal = 1'b0;
      mData_r = 32'h0BAD_0BAD;
      if (!reset) begin
        mReady = 1'b0; stall_cnt = 0; sig_active = 1'b0; last_cmd = 4'h0;
      end else begin
        if (last_cmd != 4'h0 && mReady) begin
          n_req++;
          if (last_cmd == CMD_WRITE) begin
            mem[last_addr] = last_data;
            resp_val = 32'h0BAD_0BAD;
          end else begin
            resp_val = mem_read(last_addr);
          end
          sig_active = 1'b1;
          sig_cnt = lat_cfg;
        end
        if (sig_active) begin
          if (sig_cnt == 0) begin
            mSignal = 1'b1; mData_r = resp_val; sig_active = 1'b0;
          end else sig_cnt--;
        end
        if (mCommand != 4'h0) begin
          mReady = (stall_cnt >= stall_cfg);
          stall_cnt++;
        end else begin
          mReady = 1'b0; stall_cnt = 0;
        end
        last_cmd = mCommand; last_addr = mAddress; last_data = mData;
      end
    end
  end

  // Per-cycle compare of core response and memory request against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (hSignal) begin
          if (exp_q.size() == 0) check("unexpected_hsignal", 32'(hSignal), 32'h0);
          else check("hdata", hData, exp_q.pop_front());
        end
        if (mCommand != 4'h0) begin
          check("mem_traffic_expected", 32'(cur_expect_mem), 32'h1);
          check("mcommand", 32'(mCommand), 32'(cur_cmd));
          check("maddress", mAddress, {cur_addr[31:2], 2'b00});
          if (mCommand == CMD_WRITE) check("mdata", mData, cur_data);
        end
      end
    end
  end

  task automatic do_op(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit lit_hit, input logic [31:0] lit_data, input int exp_lat,
                       input int flush_cycle, input bit chk_stall, input string name);
    int idx, cycles, req0;
    logic [31:0] tag, exp_data;
    bit hit, done;
    idx = int'((addr >> 2) % LINES);
    tag = addr >> (2 + IDX_W);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    check({name, "_model_hit"}, 32'(hit), 32'(lit_hit));
    exp_data = (cmd == CMD_WRITE) ? 32'h0 : (hit ? m_data[idx] : mem_read(addr));
    check({name, "_model_data"}, exp_data, lit_data);
    if (cmd == CMD_READ && !hit) begin
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = exp_data;
    end else if (cmd == CMD_WRITE && hit) begin
      m_data[idx] = wdata;
    end
    for (int w = 0; w < 20 && !hReady; w++) @(negedge clock);
    check({name, "_hready_before"}, 32'(hReady), 32'h1);
    exp_q.push_back(exp_data);
    cur_cmd = cmd; cur_addr = addr; cur_data = wdata;
    cur_expect_mem = (cmd == CMD_WRITE) || !hit;
    req0 = n_req;
    cCommand = cmd; cAddress = addr; cData = wdata;
    cycles = 0; done = 1'b0;
    while (!done && cycles < 200) begin
      @(negedge clock);
      cycles++;
      flush = (cycles == flush_cycle);
      if (chk_stall && cycles <= 6) begin
        check({name, "_stall_mcmd"}, 32'(mCommand), 32'(CMD_READ));
        check({name, "_stall_maddr"}, mAddress, addr);
        check({name, "_stall_hready"}, 32'(hReady), 32'h0);
        check({name, "_stall_hsignal"}, 32'(hSignal), 32'h0);
      end
      if (hSignal) done = 1'b1;
    end
    flush = 1'b0;
    cCommand = CMD_IDLE;
    check({name, "_completed"}, 32'(done), 32'h1);
    check({name, "_mem_requests"}, 32'(n_req - req0), 32'(cur_expect_mem));
    if (exp_lat >= 0) check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
    if (flush_cycle > 0) model_clear();
    @(negedge clock);
    cur_expect_mem = 1'b0;
  endtask

  initial begin
    model_clear();
    mem[32'h100] = 32'hDEADBEEF;
    repeat (3) @(negedge clock);
    check("rst_hready", 32'(hReady), 32'h1);
    check("rst_hsignal", 32'(hSignal), 32'h0);
    check("rst_hdata", hData, 32'h0);
    check("rst_mcommand", 32'(mCommand), 32'h0);
    check("rst_maddress", mAddress, 32'h0);
    check("rst_mdata", mData, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    do_op(CMD_READ,  32'h100, 0, 0, 32'hDEADBEEF, -1, 0, 0, "cold_100");
    do_op(CMD_READ,  32'h100, 0, 1, 32'hDEADBEEF,  1, 0, 0, "hit_100");
    do_op(CMD_READ,  32'h140, 0, 0, 32'h5A5A0140, -1, 0, 0, "conflict_140");
    do_op(CMD_READ,  32'h100, 0, 0, 32'hDEADBEEF, -1, 3, 0, "flush_wait_100");
    do_op(CMD_READ,  32'h100, 0, 0, 32'hDEADBEEF, -1, 0, 0, "after_flush_100");
    do_op(CMD_WRITE, 32'h100, 32'h12345678, 1, 32'h0, -1, 0, 0, "wr_hit_100");
    do_op(CMD_READ,  32'h100, 0, 1, 32'h12345678,  1, 0, 0, "rd_after_wr_100");
    do_op(CMD_WRITE, 32'h200, 32'hCAFEF00D, 0, 32'h0, -1, 0, 0, "wr_miss_200");
    do_op(CMD_READ,  32'h100, 0, 1, 32'h12345678,  1, 0, 0, "no_alloc_100");
    do_op(CMD_READ,  32'h200, 0, 0, 32'hCAFEF00D, -1, 0, 0, "rd_miss_200");
    do_op(CMD_READ,  32'h048, 0, 0, 32'h5A5A0048, -1, 5, 0, "flush_fill_048");
    do_op(CMD_READ,  32'h048, 0, 0, 32'h5A5A0048, -1, 0, 0, "refill_048");
    do_op(CMD_READ,  32'h048, 0, 1, 32'h5A5A0048,  1, 0, 0, "hit_048");

    flush = 1'b1;
    #1 check("flush_idle_hready", 32'(hReady), 32'h0);
    @(negedge clock);
    flush = 1'b0;
    model_clear();
    do_op(CMD_READ,  32'h048, 0, 0, 32'h5A5A0048, -1, 0, 0, "after_idle_flush_048");

    stall_cfg = 5;
    do_op(CMD_READ,  32'h044, 0, 0, 32'h5A5A0044, -1, 0, 1, "stall_044");
    stall_cfg = 0;
    do_op(CMD_READ,  32'h104, 0, 0, 32'h5A5A0104, -1, 0, 0, "fill_104");
    do_op(CMD_READ,  32'h104, 0, 1, 32'h5A5A0104,  1, 0, 0, "hit_104");

    cCommand = 4'h7; cAddress = 32'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("badcmd_mcommand", 32'(mCommand), 32'h0);
      check("badcmd_hready", 32'(hReady), 32'h1);
    end
    cCommand = CMD_IDLE;

    // Reset while the miss request is stalled in MISS_REQ.
    stall_cfg = 50;
    cur_cmd = CMD_READ; cur_addr = 32'h208; cur_data = 0; cur_expect_mem = 1'b1;
    cCommand = CMD_READ; cAddress = 32'h208;
    for (int w = 0; w < 10 && mCommand != CMD_READ; w++) @(negedge clock);
    check("rstmid_req_seen", 32'(mCommand), 32'(CMD_READ));
    reset = 1'b0;
    #1;
    check("rstmid_mcommand", 32'(mCommand), 32'h0);
    check("rstmid_hsignal", 32'(hSignal), 32'h0);
    check("rstmid_maddress", mAddress, 32'h0);
    cCommand = CMD_IDLE; cur_expect_mem = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stall_cfg = 0;
    @(negedge clock);
    check("rstmid_hready_after", 32'(hReady), 32'h1);
    repeat (3) @(negedge clock);
    do_op(CMD_READ,  32'h104, 0, 0, 32'h5A5A0104, -1, 0, 0, "post_rst_104");
    do_op(CMD_READ,  32'h048, 0, 0, 32'h5A5A0048, -1, 0, 0, "post_rst_048");

    check("resp_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/read_cache.md
READ_CACHE -- requirements
Module: ReadCache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cCommand  input  4  core request: 4'h0 IDLE, 4'h1 READ, 4'h2 WRITE; other codes treated as IDLE.
REQ-005 SHALL have port cAddress  input  32  core byte address; bits [1:0] ignored.
REQ-006 SHALL have port cData  input  32  core write data.
REQ-007 SHALL have port hReady  output  1  block can accept a core request this cycle.
REQ-008 SHALL have port hSignal  output  1  one-cycle core response strobe.
REQ-009 SHALL have port hData  output  32  read data, valid only while hSignal=1.
REQ-010 SHALL have port flush  input  1  invalidate all lines.
REQ-011 SHALL have port mCommand  output  4  memory request, same encoding as cCommand.
REQ-012 SHALL have ports mAddress  output  32 and mData  output  32  memory address and write data.
REQ-013 SHALL have ports mReady  input  1, mSignal  input  1, mData_r  input  32  memory-side ready, response strobe, read data.

Function
REQ-014 SHALL accept a core request on a cycle where hReady=1 and cCommand is READ or WRITE; core holds cCommand/cAddress/cData stable until hSignal.
REQ-015 SHALL split the word address: index = cAddress[2 +: log2(LINES)], tag = cAddress[31 : 2+log2(LINES)]; each line stores valid, tag, 32-bit data.
REQ-016 SHALL implement states IDLE, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT, RESP; hReady=1 only in IDLE.
REQ-017 SHALL, on READ hit accepted in cycle N, go IDLE->RESP and assert hSignal with line data in cycle N+1; no memory traffic.
REQ-018 SHALL, on READ miss, go IDLE->MISS_REQ, drive mCommand=READ, mAddress={cAddress[31:2],2'b00} until a cycle with mReady=1, then MISS_WAIT.
REQ-019 SHALL, in MISS_WAIT on mSignal=1, write mData_r into the line (valid=1, new tag) and go RESP, presenting mData_r on hData with hSignal the next cycle.
REQ-020 SHALL treat WRITE as write-through, no-allocate: IDLE->WR_REQ drives mCommand=WRITE, mAddress, mData=cData until mReady=1; WR_WAIT until mSignal; then RESP with hData=0.
REQ-021 SHALL update the line data on WRITE only if it hits; a write miss leaves the array unchanged.
REQ-022 SHALL drive mCommand=IDLE, hSignal=0 in all other states; RESP lasts exactly one cycle then returns to IDLE.
REQ-023 SHALL, on flush=1 in IDLE, clear all valid bits at that edge and hold hReady=0 that cycle.
REQ-024 SHALL, on flush=1 while busy, latch a pending flush applied on the RESP->IDLE edge, after the fill; the in-flight response still completes normally.
REQ-025 SHALL give flush priority over a simultaneous fill: the line ends invalid.
REQ-026 SHALL ignore mSignal outside MISS_WAIT/WR_WAIT.

Reset
REQ-027 SHALL, on reset=0 (asynchronous, even mid-transaction), enter IDLE, clear all valid bits and pending flush, drive hReady=1, hSignal=0, hData=0, mCommand=IDLE, mAddress=0, mData=0.
REQ-028 SHALL not replay or complete an interrupted transaction after reset deasserts.

Structure
REQ-029 SHALL take command codes (IDLE/READ/WRITE) and state encodings from a shared package also used by the core and memory models.
REQ-030 SHALL place tag/valid/data storage in one sub-module CacheArray (one read port, one write port, bulk valid clear).

Verification
REQ-031 SHALL test: READ 0x100 cold -> one mCommand=READ 0x100; mem returns 0xDEADBEEF; hSignal with hData=0xDEADBEEF; repeat READ 0x100 -> hSignal at N+1, no memory request.
REQ-032 SHALL test: LINES=16, READ 0x100 then READ 0x140 (same index) -> both miss; READ 0x100 again -> miss.
REQ-033 SHALL test: WRITE 0x100=0x12345678 after fill -> memory WRITE issued; READ 0x100 hits returning 0x12345678; WRITE 0x200 miss -> READ 0x200 misses.
REQ-034 SHALL test: flush asserted during MISS_WAIT for 0x100 -> response 0xDEADBEEF delivered; following READ 0x100 misses.
REQ-035 SHALL test: reset=0 in MISS_REQ with mReady=0 -> mCommand=IDLE immediately, hReady=1 after release, prior hits now miss.
REQ-036 SHALL test: mReady held 0 for 5 cycles -> mCommand/mAddress stable throughout, hReady=0, hSignal never asserted early.
